// File: rtl/alu_issue.sv
// RV32I ALU issue stage: decodes OP/OP-IMM/LUI/AUIPC into ALU/shifter controls behind one output register.
// Define ALU_ISSUE_SKID_EN to add a one-entry skid buffer that registers in_ready.
module alu_issue #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [2:0]      out_aluop,
  output logic            out_shift_sel,
  output logic [1:0]      out_shift_op,
  output logic [4:0]      out_rd,
  output logic            out_wen,
  output logic            out_illegal
);

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SLTU = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  localparam logic [1:0] SH_SLL = 2'b00;
  localparam logic [1:0] SH_SRL = 2'b01;
  localparam logic [1:0] SH_SRA = 2'b11;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [2:0]      aluop;
    logic            shift_sel;
    logic [1:0]      shift_op;
    logic [4:0]      rd;
    logic            wen;
    logic            illegal;
  } issue_t;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic            is_op, f7_base, f7_alt, legal;
  logic [XLEN-1:0] imm_i, imm_u;
  issue_t          dec, out_q;
  logic            in_fire, out_fire;

  assign opcode  = in_inst[6:0];
  assign funct3  = in_inst[14:12];
  assign funct7  = in_inst[31:25];
  assign is_op   = (opcode == OPC_OP);
  assign f7_base = (funct7 == 7'b0000000);
  assign f7_alt  = (funct7 == 7'b0100000);
  assign imm_i   = {{20{in_inst[31]}}, in_inst[31:20]};
  assign imm_u   = {in_inst[31:12], 12'b0};

  // NOTE: every field gets a default before the case so no path through the decoder infers a latch.
  always_comb begin
    dec       = '0;
    dec.aluop = ALU_ADD;
    legal     = 1'b1;
    unique case (opcode)
      OPC_OP, OPC_IMM: begin
        dec.a = in_rs1;
        dec.b = is_op ? in_rs2 : imm_i;
        // OP-IMM non-shift ops carry immediate bits in funct7, so only OP constrains it.
        unique case (funct3)
          3'b000: begin
            dec.aluop = (is_op && f7_alt) ? ALU_SUB : ALU_ADD;
            legal     = !is_op || f7_base || f7_alt;
          end
          3'b001: begin
            dec.shift_sel = 1'b1;
            dec.shift_op  = SH_SLL;
            legal         = f7_base;
          end
          3'b010: begin dec.aluop = ALU_SLT;  legal = !is_op || f7_base; end
          3'b011: begin dec.aluop = ALU_SLTU; legal = !is_op || f7_base; end
          3'b100: begin dec.aluop = ALU_XOR;  legal = !is_op || f7_base; end
          3'b110: begin dec.aluop = ALU_OR;   legal = !is_op || f7_base; end
          3'b111: begin dec.aluop = ALU_AND;  legal = !is_op || f7_base; end
          3'b101: begin
            dec.shift_sel = 1'b1;
            dec.shift_op  = f7_alt ? SH_SRA : SH_SRL;
            legal         = f7_base || f7_alt;
          end
        endcase
      end
      OPC_LUI:   dec.b = imm_u;
      OPC_AUIPC: begin dec.a = in_pc; dec.b = imm_u; end
      default:   legal = 1'b0;
    endcase
    if (!legal) begin
      dec         = '0;
      dec.aluop   = ALU_ADD;
      dec.illegal = 1'b1;
    end
    dec.rd  = in_inst[11:7];
    dec.wen = legal && (in_inst[11:7] != 5'd0);
  end

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

`ifdef ALU_ISSUE_SKID_EN
  issue_t skid_q;
  logic   skid_valid, skid_valid_nxt, skid_load, skid_drain, in_ready_q;

  assign skid_load      = in_fire && out_valid && !out_ready;
  assign skid_drain     = skid_valid && (!out_valid || out_ready);
  assign skid_valid_nxt = skid_load || (skid_valid && !skid_drain);
  assign in_ready       = in_ready_q && resetn;

  // NOTE: skid_q holds data only; skid_valid qualifies it, so its contents need no reset.
  always_ff @(posedge clk) begin
    if (skid_load) skid_q <= dec;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      out_valid  <= 1'b0;
      out_q      <= '0;
      skid_valid <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      skid_valid <= skid_valid_nxt;
      in_ready_q <= !skid_valid_nxt;
      if (skid_drain) begin
        out_q     <= skid_q;
        out_valid <= 1'b1;
      end else if (in_fire && !skid_load) begin
        out_q     <= dec;
        out_valid <= 1'b1;
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end
    end
  end
`else
  assign in_ready = resetn && (!out_valid || out_ready);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      out_valid <= 1'b0;
      out_q     <= '0;
    end else if (in_fire) begin
      out_q     <= dec;
      out_valid <= 1'b1;
    end else if (out_fire) begin
      out_valid <= 1'b0;
    end
  end
`endif

  assign out_a         = out_q.a;
  assign out_b         = out_q.b;
  assign out_aluop     = out_q.aluop;
  assign out_shift_sel = out_q.shift_sel;
  assign out_shift_op  = out_q.shift_op;
  assign out_rd        = out_q.rd;
  assign out_wen       = out_q.wen;
  assign out_illegal   = out_q.illegal;

endmodule
